// File: rtl/spi_master.sv
// SPI master: serializes DATA_W-bit words MSB-first on mosi and captures miso, with
// CPOL/CPHA fixed at elaboration and back-to-back words under one ss assertion.
module spi_master #(
  parameter int CPOL    = 1,
  parameter int CPHA    = 1,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              scl,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam logic IDLE_SCL = 1'(CPOL);
  localparam logic PHA      = 1'(CPHA);
  localparam int   CW       = $clog2(CLK_DIV);
  localparam int   EW       = $clog2(2 * DATA_W + 1);

  localparam logic [CW-1:0] CNT_LAST     = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_RDY      = CW'(CLK_DIV - 2);
  // edge_r value just before the closing (2*DATA_W-th) edge is generated
  localparam logic [EW-1:0] EDGE_FINAL   = EW'(2 * DATA_W - 1);
  localparam logic [EW-1:0] SAMPLE_FINAL = PHA ? EW'(2 * DATA_W) : EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [EW-1:0]     edge_r;
  logic [DATA_W-1:0] tx_shift_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic              sample_r;
  logic              last_sample_r;

  logic [EW-1:0]     edge_next_s;
  logic              leading_s;
  logic              sample_edge_s;
  logic              drive_edge_s;
  logic              half_end_s;
  logic              accept_s;
  logic [DATA_W-1:0] load_shift_s;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    shift_in = (v << 1) | DATA_W'(b);
  endfunction

  // Decode what the next scl edge means for sampling and driving
  always_comb begin
    edge_next_s   = edge_r + EW'(1);
    leading_s     = ~edge_r[0];
    sample_edge_s = (leading_s != PHA);
    half_end_s    = (cnt_r == CNT_LAST);
    accept_s      = tx_valid && tx_ready;
    if (PHA) begin
      drive_edge_s = leading_s;
      load_shift_s = tx_data;
    end else begin
      // CPHA=0 already drove the MSB at accept; the closing trailing edge has no next bit
      drive_edge_s = ~leading_s && (edge_r != EDGE_FINAL);
      load_shift_s = tx_data << 1;
    end
  end

  // Word FSM, half-period timing, serial shifting and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      edge_r        <= '0;
      tx_shift_r    <= '0;
      rx_shift_r    <= '0;
      sample_r      <= 1'b0;
      last_sample_r <= 1'b0;
      tx_ready      <= 1'b1;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      busy          <= 1'b0;
      scl           <= IDLE_SCL;
      ss            <= 1'b1;
      mosi          <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      sample_r <= 1'b0;

      // miso is captured in the cycle the sampling edge is visible on scl
      if (sample_r) begin
        rx_shift_r <= shift_in(rx_shift_r, miso);
        if (last_sample_r) begin
          rx_data  <= shift_in(rx_shift_r, miso);
          rx_valid <= 1'b1;
        end
      end

      if (state_r != IDLE) begin
        cnt_r <= half_end_s ? '0 : cnt_r + CW'(1);
      end

      if ((state_r == SETUP || state_r == SHIFT) && half_end_s) begin
        scl    <= ~scl;
        edge_r <= edge_next_s;
        if (sample_edge_s) begin
          sample_r      <= 1'b1;
          last_sample_r <= (edge_next_s == SAMPLE_FINAL);
        end
        if (drive_edge_s) begin
          mosi       <= tx_shift_r[DATA_W-1];
          tx_shift_r <= tx_shift_r << 1;
        end
      end

      if (accept_s) begin
        tx_shift_r <= load_shift_s;
        edge_r     <= '0;
        cnt_r      <= '0;
        state_r    <= SETUP;
        ss         <= 1'b0;
        busy       <= 1'b1;
        tx_ready   <= 1'b0;
        if (!PHA) begin
          mosi <= tx_data[DATA_W-1];
        end
      end else begin
        case (state_r)
          IDLE: begin
            cnt_r <= '0;
          end
          SETUP: begin
            if (half_end_s) begin
              state_r <= SHIFT;
            end
          end
          SHIFT: begin
            if (half_end_s && edge_r == EDGE_FINAL) begin
              state_r <= HOLD;
            end
          end
          HOLD: begin
            if (cnt_r == CNT_RDY) begin
              tx_ready <= 1'b1;
            end
            if (half_end_s) begin
              tx_ready <= 1'b0;
              ss       <= 1'b1;
              state_r  <= GAP;
            end
          end
          GAP: begin
            if (half_end_s) begin
              state_r  <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end
          end
          default: begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            ss       <= 1'b1;
            scl      <= IDLE_SCL;
            tx_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master: modes 0 and 3, back-to-back words,
// flow control, mid-word reset and 16-bit loopback in all four modes.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Compare an observed value against its expectation and count the result
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0 instance
  logic       tx_valid0 = 1'b0, tx_ready0, rx_valid0, busy0, scl0, ss0, mosi0, miso0 = 1'b0;
  logic [7:0] tx_data0 = 8'h00, rx_data0;
  // mode 3 instance
  logic       tx_valid3 = 1'b0, tx_ready3, rx_valid3, busy3, scl3, ss3, mosi3, miso3 = 1'b0;
  logic [7:0] tx_data3 = 8'h00, rx_data3;
  // loopback instances, index = {CPOL, CPHA}
  logic [3:0]  lb_valid = 4'h0, lb_ready, lb_rxv, lb_busy, lb_scl, lb_ss, lb_mosi;
  logic [15:0] lb_rx [4];

  spi_master #(.CPOL(0), .CPHA(0), .DATA_W(8), .CLK_DIV(4)) u0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_data(tx_data0),
    .rx_valid(rx_valid0), .rx_data(rx_data0), .busy(busy0), .scl(scl0), .ss(ss0),
    .mosi(mosi0), .miso(miso0));

  spi_master #(.CPOL(1), .CPHA(1), .DATA_W(8), .CLK_DIV(4)) u3 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid3), .tx_ready(tx_ready3), .tx_data(tx_data3),
    .rx_valid(rx_valid3), .rx_data(rx_data3), .busy(busy3), .scl(scl3), .ss(ss3),
    .mosi(mosi3), .miso(miso3));

  genvar gm;
  generate
    for (gm = 0; gm < 4; gm++) begin : g_lb
      spi_master #(.CPOL(gm / 2), .CPHA(gm % 2), .DATA_W(16), .CLK_DIV(5)) u_lb (
        .clk(clk), .rst(rst), .tx_valid(lb_valid[gm]), .tx_ready(lb_ready[gm]),
        .tx_data(16'hBEEF), .rx_valid(lb_rxv[gm]), .rx_data(lb_rx[gm]), .busy(lb_busy[gm]),
        .scl(lb_scl[gm]), .ss(lb_ss[gm]), .mosi(lb_mosi[gm]), .miso(lb_mosi[gm]));
    end
  endgenerate

  // mode 0 slave: MSB ready at ss fall, next bit on each falling (trailing) edge
  logic [7:0] pat0 = 8'h3C;
  int   idx0 = 7;
  logic first0 = 1'b1;
  always @(negedge ss0 or posedge ss0 or negedge scl0) begin
    if (ss0 === 1'b1) first0 = 1'b1;
    else if (ss0 === 1'b0) begin
      if (first0) begin first0 = 1'b0; miso0 = pat0[7]; idx0 = 6; end
      else begin miso0 = pat0[idx0]; idx0 = (idx0 == 0) ? 7 : idx0 - 1; end
    end
  end

  // mode 3 slave: next bit on each falling (leading) edge, word-aligned by bit count
  logic [7:0] pat3 = 8'hC3;
  int idx3 = 7;
  always @(posedge ss3 or negedge scl3) begin
    if (ss3 === 1'b1) idx3 = 7;
    else if (ss3 === 1'b0) begin miso3 = pat3[idx3]; idx3 = (idx3 == 0) ? 7 : idx3 - 1; end
  end

  // mosi as seen by the slave at its sampling edges
  logic [23:0] cap0 = 24'h0, cap3 = 24'h0;
  always @(posedge scl0) cap0 = {cap0[22:0], mosi0};
  always @(posedge scl3) cap3 = {cap3[22:0], mosi3};

  int rxcnt0 = 0, rxcnt3 = 0;
  always @(negedge clk) begin
    if (rx_valid0 === 1'b1) rxcnt0++;
    if (rx_valid3 === 1'b1) rxcnt3++;
  end

  // One mode-3 word from an idle DUT; n counts cycles from T (n = 0)
  task automatic run3(input logic [7:0] d, output int rx_n, output int ss_rise_n,
                      output int idle_n, output int edge1_n, output int edges);
    logic scl_prev;
    @(negedge clk);
    tx_data3 = d; tx_valid3 = 1'b1;
    @(posedge clk); #1;
    tx_valid3 = 1'b0;
    rx_n = -1; ss_rise_n = -1; idle_n = -1; edge1_n = -1; edges = 0;
    scl_prev = scl3;
    for (int n = 0; n < 200 && idle_n < 0; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (scl3 !== scl_prev) begin edges++; if (edge1_n < 0) edge1_n = n; end
      scl_prev = scl3;
      if (rx_valid3 === 1'b1 && rx_n < 0) rx_n = n;
      if (ss3 === 1'b1 && ss_rise_n < 0) ss_rise_n = n;
      if (busy3 === 1'b0 && idle_n < 0) idle_n = n;
    end
  endtask

  int rx_n, ss_rise_n, idle_n, edge1_n, edges, rx0, words, ne, ss_hi;
  int edge_n [64];
  int lb_cnt [4];
  int lb_rxn [4];
  logic rdy_prev, scl_prev;

  initial begin
    // reset state
    repeat (2) @(posedge clk); #1;
    check("rst_ss0", ss0, 1'b1);
    check("rst_scl0", scl0, 1'b0);
    check("rst_mosi0", mosi0, 1'b0);
    check("rst_ready0", tx_ready0, 1'b1);
    check("rst_busy0", busy0, 1'b0);
    check("rst_scl3", scl3, 1'b1);
    check("rst_ss3", ss3, 1'b1);
    check("rst_rxv3", rx_valid3, 1'b0);
    check("rst_rxd3", rx_data3, 8'h00);
    check("rst_lb_ready", lb_ready, 4'hF);
    check("rst_lb_scl", lb_scl, 4'hC);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // mode 0 single word
    tx_data0 = 8'hA5; tx_valid0 = 1'b1;
    @(posedge clk); #1;
    tx_valid0 = 1'b0; rx_n = -1; ss_rise_n = -1; rx0 = rxcnt0;
    check("m0_ss_fall", ss0, 1'b0);
    check("m0_busy", busy0, 1'b1);
    for (int n = 0; n < 120 && ss_rise_n < 0; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (rx_valid0 === 1'b1 && rx_n < 0) rx_n = n;
      if (ss0 === 1'b1 && ss_rise_n < 0) ss_rise_n = n;
    end
    repeat (6) @(negedge clk);
    check("m0_ss_low_cycles", ss_rise_n, 68);
    check("m0_rx_cycle", rx_n, 61);
    check("m0_rx_data", rx_data0, 8'h3C);
    check("m0_mosi_bits", cap0[7:0], 8'hA5);
    check("m0_scl_end", scl0, 1'b0);
    check("m0_rx_pulses", rxcnt0 - rx0, 1);
    check("m0_idle", busy0, 1'b0);

    // mode 3 single word, tx_valid dropped after accept (flow control)
    rx0 = rxcnt3;
    run3(8'h5A, rx_n, ss_rise_n, idle_n, edge1_n, edges);
    check("m3_rx_cycle", rx_n, 65);
    check("m3_ss_rise", ss_rise_n, 68);
    check("m3_gap_idle", idle_n, 72);
    check("m3_ready_idle", tx_ready3, 1'b1);
    check("m3_edge1", edge1_n, 4);
    check("m3_edges", edges, 16);
    check("m3_scl_idle", scl3, 1'b1);
    check("m3_mosi_bits", cap3[7:0], 8'h5A);
    check("m3_rx_data", rx_data3, 8'hC3);
    repeat (3) @(negedge clk);
    check("m3_rx_pulses", rxcnt3 - rx0, 1);

    // later accept restarts with ss low for one half-period before edge 1
    run3(8'hE1, rx_n, ss_rise_n, idle_n, edge1_n, edges);
    check("fc_edge1", edge1_n, 4);
    check("fc_mosi_bits", cap3[7:0], 8'hE1);
    check("fc_rx_data", rx_data3, 8'hC3);

    // back-to-back: three words with tx_valid held high
    @(negedge clk);
    tx_data3 = 8'h11; tx_valid3 = 1'b1;
    words = 0; ne = 0; ss_hi = 0; scl_prev = scl3; rx0 = rxcnt3;
    for (int n = 0; n < 600; n++) begin
      rdy_prev = tx_ready3;
      @(posedge clk); #1;
      if (rdy_prev && tx_valid3) begin
        words++;
        case (words)
          1: tx_data3 = 8'h22;
          2: tx_data3 = 8'h33;
          default: tx_valid3 = 1'b0;
        endcase
      end
      if (scl3 !== scl_prev) begin if (ne < 64) edge_n[ne] = n; ne++; end
      scl_prev = scl3;
      if (words > 0 && ne < 48 && ss3 === 1'b1) ss_hi++;
      @(negedge clk);
      if (words == 3 && busy3 === 1'b0) break;
    end
    check("b2b_words", words, 3);
    check("b2b_edges", ne, 48);
    check("b2b_ss_high", ss_hi, 0);
    check("b2b_rx_pulses", rxcnt3 - rx0, 3);
    check("b2b_gap1", edge_n[16] - edge_n[15], 8);
    check("b2b_gap2", edge_n[32] - edge_n[31], 8);
    check("b2b_half", edge_n[17] - edge_n[16], 4);
    check("b2b_mosi_bits", cap3, 24'h112233);
    check("b2b_rx_data", rx_data3, 8'hC3);

    // reset asserted during edge 7
    @(negedge clk);
    tx_data3 = 8'h96; tx_valid3 = 1'b1;
    @(posedge clk); #1;
    tx_valid3 = 1'b0; ne = 0; scl_prev = scl3; rx0 = rxcnt3;
    for (int n = 0; n < 100 && ne < 7; n++) begin
      @(posedge clk); #1;
      if (scl3 !== scl_prev) ne++;
      scl_prev = scl3;
    end
    check("mid_edge7_reached", ne, 7);
    check("mid_mosi_bit4", mosi3, 1'b1);
    rst = 1'b1; #1;
    check("mid_ss", ss3, 1'b1);
    check("mid_scl", scl3, 1'b1);
    check("mid_mosi", mosi3, 1'b0);
    check("mid_busy", busy3, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_no_rxv", rxcnt3 - rx0, 0);
    check("mid_rx_data_cleared", rx_data3, 8'h00);
    run3(8'h3D, rx_n, ss_rise_n, idle_n, edge1_n, edges);
    check("post_rx_cycle", rx_n, 65);
    check("post_edges", edges, 16);
    check("post_mosi_bits", cap3[7:0], 8'h3D);
    check("post_rx_data", rx_data3, 8'hC3);

    // loopback in all four modes, DATA_W=16, CLK_DIV=5
    @(negedge clk);
    lb_valid = 4'hF;
    @(posedge clk); #1;
    lb_valid = 4'h0;
    for (int m = 0; m < 4; m++) begin lb_cnt[m] = 0; lb_rxn[m] = -1; end
    for (int n = 0; n < 250; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      for (int m = 0; m < 4; m++) begin
        if (lb_rxv[m] === 1'b1) begin lb_cnt[m]++; lb_rxn[m] = n; end
      end
    end
    for (int m = 0; m < 4; m++) begin
      check("lb_rx_data", lb_rx[m], 16'hBEEF);
      check("lb_rx_pulses", lb_cnt[m], 1);
      check("lb_rx_cycle", lb_rxn[m], (m % 2 == 1) ? 161 : 156);
      check("lb_scl_idle", lb_scl[m], (m >= 2) ? 1'b1 : 1'b0);
      check("lb_ss_idle", lb_ss[m], 1'b1);
      check("lb_busy_idle", lb_busy[m], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI master for the SPI link. Serializes parallel words MSB-first onto `mosi` and captures `miso` into parallel words. It generates `scl` and `ss` from the system clock, with CPOL/CPHA selected at elaboration. It is the initiating end for `spi_slave` instances in the same design and supports back-to-back words under a single `ss` assertion.

## Interface
- `CPOL`, default 1: idle level of `scl`.
- `CPHA`, default 1: 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- `DATA_W`, default 8: bits per word, 1..128.
- `CLK_DIV`, default 4: `clk` cycles per `scl` half-period; minimum 4, because the slave oversamples `scl`.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `tx_valid`  input  1  `tx_data` is offered.
- `tx_ready`  output  1  word accepted when `tx_valid && tx_ready`.
- `tx_data`  input  DATA_W  word to send, MSB first.
- `rx_valid`  output  1  one-cycle pulse; `rx_data` holds a new word.
- `rx_data`  output  DATA_W  last received word.
- `busy`  output  1  high in every state except IDLE.
- `scl`  output  1  serial clock.
- `ss`  output  1  active-low slave select.
- `mosi`  output  1  serial data out.
- `miso`  input  1  serial data in.

## Operation
- **States**
  - IDLE: `ss`=1, `scl`=CPOL. Exits on accept.
  - SETUP: one half-period with `ss`=0 and `scl` idle.
  - SHIFT: 2·DATA_W half-periods; `scl` toggles at the end of each half-period.
  - HOLD: one half-period with `scl` idle and `ss`=0.
  - GAP: one half-period with `ss`=1. Always returns to IDLE.
- **HOLD exit**
  - If `tx_valid` is high on the last HOLD cycle, the next word is accepted and the FSM goes to SETUP with `ss` kept low.
  - Otherwise the FSM goes to GAP.
- **`tx_ready`**: high in IDLE, and on the last HOLD cycle; low everywhere else.
- **Edges**
  - Edges are numbered 1..2·DATA_W. Odd edges are leading (away from CPOL); even edges are trailing.
  - `scl` always ends each word at CPOL.
- **CPHA=0**
  - `mosi` = MSB from the first SETUP cycle.
  - `mosi` advances to the next bit on each trailing edge.
  - `miso` is sampled on each leading edge.
- **CPHA=1**
  - `mosi` drives the MSB at edge 1, then the next bit on each subsequent leading edge.
  - `miso` is sampled on each trailing edge.
- **Sampling**
  - `miso` is captured in the same `clk` cycle that the sampling edge appears on `scl`.
  - Captured bits shift into the LSB, so the first received bit ends in `rx_data[DATA_W-1]`.
- **After a word**
  - `mosi` holds its last driven value until the next word's first drive point.
  - `rx_data` holds until the next `rx_valid`.
- **Flow control**: `tx_data` is sampled only on the accept cycle; later changes are ignored.
- **Reset mid-word**
  - Word is aborted immediately.
  - No `rx_valid` is generated.
  - All outputs take their reset values.
- **Reset values**
  - `ss`=1, `scl`=CPOL, `mosi`=0.
  - `rx_data`=0, `rx_valid`=0, `busy`=0.
  - `tx_ready`=1 (IDLE); `tx_valid` is ignored while `rst` is high.

## Timing
- **Reference point**: accept occurs at cycle A; let H = CLK_DIV and T = A+1.
- **Word boundaries**
  - `ss` falls and `busy` rises at T.
  - Edge k appears on `scl` at T + k·H, for k = 1..2·DATA_W.
  - HOLD spans T + 2·DATA_W·H to T + (2·DATA_W+1)·H − 1.
  - `tx_ready` is high only on the last cycle of that span.
- **Isolated word**
  - `ss` rises at T + (2·DATA_W+1)·H.
  - IDLE is reached, `busy` falls and `tx_ready` rises at T + (2·DATA_W+2)·H.
- **Back-to-back word**
  - Continuation accept at A' = T + (2·DATA_W+1)·H − 1.
  - The next word's T' = A' + 1; `ss` never rises.
  - Gap between the last edge of one word and the first edge of the next is exactly 2·H.
- **`rx_valid` timing**
  - CPHA=1: pulse at T + 2·DATA_W·H + 1.
  - CPHA=0: pulse at T + (2·DATA_W−1)·H + 1.
- **Throughput**: isolated word-to-word period is (2·DATA_W+2)·H + 1 cycles.

## Test plan
- **Mode 0 single word** (CPOL=0, CPHA=0, DATA_W=8, CLK_DIV=4)
  - Stimulus: `tx_data`=0xA5; bench model drives `miso`=0x3C, updating on trailing edges.
  - Required: `mosi` bits 1,0,1,0,0,1,0,1 at leading edges.
  - Required: `rx_data`=0x3C, `rx_valid` at T+61.
  - Required: `ss` low exactly 68 cycles; `scl` returns to 0.
- **Mode 3 single word** (CPOL=1, CPHA=1)
  - Stimulus: `tx_data`=0x5A; `miso` model returns 0xC3.
  - Required: `scl` idles at 1, exactly 16 edges.
  - Required: `mosi` stable at every rising edge with the bits of 0x5A.
  - Required: `rx_data`=0xC3, `rx_valid` at T+65.
- **Back-to-back** (mode 3)
  - Stimulus: 3 words 0x11, 0x22, 0x33 with `tx_valid` held high.
  - Required: `ss` stays low across all 48 edges.
  - Required: exactly 3 `rx_valid` pulses; inter-word edge gap = 8 cycles.
- **Flow control**
  - Stimulus: drop `tx_valid` after the first word.
  - Required: `ss` rises, GAP lasts 4 cycles, IDLE reached.
  - Required: a later accept restarts with `ss` low for 4 cycles before edge 1.
- **Reset mid-word**
  - Stimulus: assert `rst` during edge 7 of a word.
  - Required: `ss`=1, `scl`=CPOL and `mosi`=0 asynchronously; no `rx_valid`.
  - Required: the next word after release transfers correctly.
- **Loopback across all four modes** (`miso` tied to `mosi`, DATA_W=16, CLK_DIV=5)
  - Stimulus: send 0xBEEF in each mode.
  - Required: `rx_data`=0xBEEF for CPHA=1.
  - Required: `rx_data`=0xBEEF for CPHA=0 with the model sampling on the correct edge.
